// File: rtl/coord_gen.sv
// coord_gen: streams N_LANES complex coordinates per beat across an H_RES x V_RES raster.
// Define COORD_GEN_SAT_EN to saturate lane and c_img arithmetic instead of wrapping.
module coord_gen #(
    parameter int N       = 16,
    parameter int Q       = 11,
    parameter int N_LANES = 4,
    parameter int H_RES   = 800,
    parameter int V_RES   = 600,
    parameter int ZOOM_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [N-1:0]         x_min,
    input  logic [N-1:0]         y_max,
    input  logic [ZOOM_W-1:0]    zoom_level,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [N*N_LANES-1:0] c_real,
    output logic [N-1:0]         c_img,
    output logic [15:0]          pix_x,
    output logic [15:0]          pix_y,
    output logic                 last,
    output logic                 busy,
    output logic                 done
);
    localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, DONE = 2'd3;
    localparam int SW = $clog2(N);
    logic [1:0]    state;
    logic [N-1:0]  x_min_r, y_max_r, step, row_inc;
    logic [SW-1:0] sh;
    logic          xfer, row_end, frame_end;
    function automatic logic [N-1:0] add_s(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] s;
        s = a + b;
`ifdef COORD_GEN_SAT_EN
        if (a[N-1] == b[N-1] && s[N-1] != a[N-1]) s = {a[N-1], {(N-1){!a[N-1]}}};
`endif
        return s;
    endfunction
    function automatic logic [N-1:0] sub_s(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] s;
        s = a - b;
`ifdef COORD_GEN_SAT_EN
        if (a[N-1] != b[N-1] && s[N-1] != a[N-1]) s = {a[N-1], {(N-1){!a[N-1]}}};
`endif
        return s;
    endfunction
    // Steps are powers of two, so lane offsets are shifts of the latched exponent.
    assign step      = N'(1) << sh;
    assign row_inc   = N'(N_LANES) << sh;
    assign xfer      = out_valid && out_ready;
    assign row_end   = pix_x == 16'(H_RES - N_LANES);
    assign frame_end = row_end && pix_y == 16'(V_RES - 1);
    assign last      = out_valid && frame_end;
    assign busy      = state == LOAD || state == RUN;
    assign done      = state == DONE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            c_real    <= '0;
            c_img     <= '0;
            pix_x     <= '0;
            pix_y     <= '0;
            x_min_r   <= '0;
            y_max_r   <= '0;
            sh        <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    x_min_r <= x_min;
                    y_max_r <= y_max;
                    sh      <= SW'(Q - 8) - SW'(zoom_level);
                    state   <= LOAD;
                end
                LOAD: if (abort) state <= IDLE;
                else begin
                    for (int k = 0; k < N_LANES; k++) c_real[k*N +: N] <= add_s(x_min_r, N'(k) << sh);
                    c_img     <= y_max_r;
                    pix_x     <= '0;
                    pix_y     <= '0;
                    out_valid <= 1'b1;
                    state     <= RUN;
                end
                RUN: begin
                    if (xfer) begin
                        for (int k = 0; k < N_LANES; k++)
                            c_real[k*N +: N] <= row_end ? add_s(x_min_r, N'(k) << sh) : add_s(c_real[k*N +: N], row_inc);
                        pix_x <= row_end ? '0 : pix_x + 16'(N_LANES);
                        if (row_end) begin
                            c_img <= sub_s(c_img, step);
                            pix_y <= pix_y + 16'd1;
                        end
                    end
                    if (abort || (xfer && frame_end)) begin
                        out_valid <= 1'b0;
                        state     <= abort ? IDLE : DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/coord_gen.md
Name: coord_gen

Overview:
- Sequential successor to the per-pixel coordinate fetch stage.
- Walks a full H_RES x V_RES raster and emits, per beat, N_LANES adjacent complex coordinates (c_real per lane, one shared c_img) to the MBT worker array.
- Uses a valid/ready handshake and incremental accumulation (no multipliers).
- Sits between frame control (start, viewport, zoom) and the N_LANES MBT modules.

Parameters:
- N, 16, total fixed-point width, two's complement.
- Q, 11, fractional bits.
- N_LANES, 4, coordinates per beat; H_RES % N_LANES == 0 required.
- H_RES, 800, pixels per row.
- V_RES, 600, rows per frame.
- ZOOM_W, 2, zoom_level width; requires Q >= 8 + 2^ZOOM_W - 1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  frame request, sampled only in IDLE
- abort  in  1  terminate current frame
- x_min  in  N  left edge real coordinate, latched at start
- y_max  in  N  top edge imaginary coordinate, latched at start
- zoom_level  in  ZOOM_W  latched at start; step = 2^-(8+zoom_level)
- out_ready  in  1  MBT array accepts beat
- out_valid  out  1  beat valid
- c_real  out  N*N_LANES  lane k at [k*N +: N]
- c_img  out  N  shared imaginary coordinate for the beat
- pix_x  out  16  column of lane 0
- pix_y  out  16  row
- last  out  1  final beat of frame, qualified by out_valid
- busy  out  1  high in LOAD and RUN
- done  out  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset: state IDLE; out_valid, last, busy, done = 0; c_real, c_img, pix_x, pix_y = 0; latched viewport = 0.
- States: IDLE, LOAD, RUN, DONE.
- IDLE, start=1: latch x_min, y_max and zoom_level, compute step = 1 << (Q-8-zoom_level) in raw LSBs, go to LOAD. start in any other state is ignored.
- LOAD (1 cycle):
  - lane k = x_min + k*step; c_img = y_max; pix_x = pix_y = 0.
  - row_inc = N_LANES*step.
  - Go to RUN.
- Latency: out_valid rises 2 cycles after start is sampled.
- RUN, out_valid=1: a beat transfers when out_ready=1. While out_ready=0, all outputs hold stable.
- On transfer, not at row end: every lane += row_inc; pix_x += N_LANES.
- Row end (pix_x == H_RES-N_LANES):
  - lanes reload x_min + k*step; pix_x = 0.
  - c_img -= step; pix_y += 1.
- last = 1 when pix_x == H_RES-N_LANES and pix_y == V_RES-1. Its transfer moves to DONE; out_valid drops the next cycle.
- DONE: done = 1 for exactly one cycle; busy = 0; return to IDLE. Beats per frame = H_RES*V_RES/N_LANES.
- abort=1 in LOAD or RUN:
  - IDLE next cycle; out_valid and busy drop next cycle; no done pulse.
  - A transfer in the abort cycle still counts.
- abort is ignored in IDLE and DONE.
- Arithmetic:
  - Without the optional feature, all adds and subtracts wrap modulo 2^N.
  - Step shift counts are constant per frame.
  - Changes to x_min, y_max or zoom_level mid-frame have no effect.
- rst mid-frame: immediate return to reset values; no done pulse.

Optional Feature:
- Macro: COORD_GEN_SAT_EN.
- Defined: each lane add and the c_img subtract saturate to 0x7FFF or 0x8000 (for N=16) on signed overflow. Saturated values remain clamped until the row reload.
- Undefined: two's-complement wrap; no saturation logic is synthesised.

Test Plan:
- Reset, then start with x_min=0xF000, y_max=0x0960, zoom=0:
  - beat 0 lanes 0xF000/0xF008/0xF010/0xF018, c_img=0x0960, pix 0/0, out_valid at start+2.
  - beat 1 lane0=0xF020, pix_x=4.
- Same frame with out_ready=1 always:
  - beat 200 has lane0=0xF000, c_img=0x0958, pix_y=1.
  - beat 119999 has pix_x=796, pix_y=599, last=1.
  - done pulses one cycle later; total 120000 beats.
- zoom=3: lanes 0xF000..0xF003, step 1. Mid-frame zoom change to 0: step stays 1.
- out_ready low for 5 cycles on beat 3: c_real, c_img, pix and out_valid stable. Beat 4 appears only after the transfer.
- abort asserted at beat 50 with out_ready=1:
  - beat 50 counts; out_valid=0 and busy=0 next cycle; done never pulses.
  - A new start restarts at pix 0/0.
- x_min=0x7F00, zoom=0:
  - beat 7 lane3 = 0x7FF8.
  - beat 8 lane0 = 0x8000 without COORD_GEN_SAT_EN; 0x7FFF with it.
